// File: rtl/mips_pipe_pkg.sv
`default_nettype none
//==============================================================================
// mips_pipe_pkg -- shared pipeline types and constants.            Rev 1.0
//==============================================================================
package mips_pipe_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
//==============================================================================
// if_fetch_stage_if -- imem request/response channel of the fetch stage. Rev 1.0
//==============================================================================
interface if_fetch_stage_if
  import mips_pipe_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               imem_req_valid;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_req_ready;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
//==============================================================================
// if_id_reg -- IF/ID pipeline register, priority flush > hold > load > bubble. Rev 1.0
//==============================================================================
module if_id_reg
  import mips_pipe_pkg::*;
#(
  parameter int                 ADDR_W  = ADDR_W_DEF,
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  npc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  npc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  npc_q;
  logic               valid_q;

  // NPC is only rewritten by a real load; flushes and bubbles leave it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        instr_q <= instr_i;
        npc_q   <= npc_i;
        valid_q <= 1'b1;
      end else begin
        instr_q <= NOP;
        valid_q <= 1'b0;
      end
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
//==============================================================================
// if_fetch_stage -- one-outstanding imem fetch FSM with hold buffer and redirect drop. Rev 1.0
//==============================================================================
module if_fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter int                 ADDR_W  = ADDR_W_DEF,
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP     = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               datastall,
  input  logic               controlstall,
  input  logic               branch_enable,
  input  logic               jump_enable,
  if_fetch_stage_if.master   imem,
  output logic [ADDR_W-1:0]  NPC_increment_4,
  output logic               pc_advance_n,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [ADDR_W-1:0]  IF_ID_NPC,
  output logic               IF_ID_valid
);

  fetch_state_t       state_q;
  logic [ADDR_W-1:0]  req_pc_q;
  logic [INSTR_W-1:0] hold_q;
  logic               stale_ok_q;

  logic               stall;
  logic               flush;
  logic               req_fire;
  logic               from_hold;
  logic               load;
  logic [INSTR_W-1:0] load_instr;
  logic [ADDR_W-1:0]  load_npc;

  assign stall     = ~(datastall & controlstall);
  assign flush     = branch_enable | jump_enable;
  assign from_hold = (state_q == S_HOLD);
  assign req_fire  = imem.imem_req_valid & imem.imem_req_ready;

  assign imem.imem_req_valid = reset & (state_q == S_REQ);
  assign imem.imem_req_addr  = PC;

  // PC advances on the same edge that IF/ID captures, so the next request sees PC+4.
  assign load = ~flush & ~stall &
                (((state_q == S_WAIT) & imem.imem_resp_valid) | from_hold);
  assign pc_advance_n    = load;
  assign load_instr      = from_hold ? hold_q : imem.imem_resp_data;
  assign load_npc        = req_pc_q + ADDR_W'(4);
  assign NPC_increment_4 = PC + ADDR_W'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_REQ;
      req_pc_q   <= '0;
      hold_q     <= NOP;
      stale_ok_q <= 1'b1;
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q   <= PC;
            stale_ok_q <= 1'b0;
            state_q    <= flush ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (flush) begin
              state_q <= S_REQ;
            end else if (stall) begin
              hold_q  <= imem.imem_resp_data;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_REQ;
            end
          end else if (flush) begin
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (flush || !stall) state_q <= S_REQ;
        end
        S_DROP: begin
          if (imem.imem_resp_valid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // A response left over from before a reset may land before the first new request.
  a_resp_solicited: assert property (@(posedge clk) disable iff (!reset)
    imem.imem_resp_valid |-> (state_q == S_WAIT || state_q == S_DROP || stale_ok_q));

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .NOP     (NOP)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .stall_i (stall),
    .load_i  (load),
    .instr_i (load_instr),
    .npc_i   (load_npc),
    .instr_o (IF_ID_instr),
    .npc_o   (IF_ID_NPC),
    .valid_o (IF_ID_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
//==============================================================================
// tb_if_fetch_stage -- directed + random fetch traffic scored against a transaction model. Rev 1.0
//==============================================================================
module tb_if_fetch_stage;
  import mips_pipe_pkg::*;

  localparam logic [31:0] NOPV = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC = 32'h0;
  logic        datastall = 1'b1, controlstall = 1'b1;
  logic        branch_enable = 1'b0, jump_enable = 1'b0;
  logic [31:0] NPC_increment_4, IF_ID_instr, IF_ID_NPC;
  logic        pc_advance_n, IF_ID_valid;

  if_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

  if_fetch_stage #(.ADDR_W(32), .INSTR_W(32), .NOP(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .PC              (PC),
    .datastall       (datastall),
    .controlstall    (controlstall),
    .branch_enable   (branch_enable),
    .jump_enable     (jump_enable),
    .imem            (imem),
    .NPC_increment_4 (NPC_increment_4),
    .pc_advance_n    (pc_advance_n),
    .IF_ID_instr     (IF_ID_instr),
    .IF_ID_NPC       (IF_ID_NPC),
    .IF_ID_valid     (IF_ID_valid)
  );

  always #5 clk = ~clk;

  // Everything observable during one cycle, predicted by the model.
  typedef struct {
    int          cyc;
    logic        rv;
    logic [31:0] addr;
    logic [31:0] npc4;
    logic        adv;
    logic        iv;
    logic [31:0] ii;
    logic [31:0] in;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // Memory responder: one response, lat cycles after acceptance.
  int          resp_at = -1;
  logic [31:0] resp_word = 32'h0;
  int          lat = 1;
  logic [31:0] next_word = 32'h0;

  // Transaction-level model: the fetch in flight and the IF/ID contents.
  bit          m_busy = 0, m_have = 0, m_killed = 0;
  logic [31:0] m_pc = 32'h0, m_data = 32'h0;
  logic        m_iv = 1'b0;
  logic [31:0] m_ii = NOPV, m_in = 32'h0;
  logic        last_adv = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
  endfunction

  task automatic cycle(input logic rstn, input logic rdy, input logic ds, input logic cs,
                       input logic br, input logic jp, input logic [31:0] pcv);
    exp_t        e;
    logic        rsp, fl, st, adv;
    logic [31:0] rdata;
    @(negedge clk);
    cyc++;
    rsp   = (cyc == resp_at);
    rdata = rsp ? resp_word : $urandom;
    reset = rstn;
    PC    = pcv;
    datastall = ds; controlstall = cs; branch_enable = br; jump_enable = jp;
    imem.imem_req_ready  = rdy;
    imem.imem_resp_valid = rsp;
    imem.imem_resp_data  = rdata;

    if (!rstn) begin
      m_busy = 0; m_have = 0; m_killed = 0;
      m_iv = 1'b0; m_ii = NOPV; m_in = 32'h0;
    end
    e.cyc  = cyc;
    e.rv   = rstn && !m_busy;
    e.addr = pcv;
    e.npc4 = pcv + 32'd4;
    e.iv   = m_iv; e.ii = m_ii; e.in = m_in;
    fl  = br | jp;
    st  = !(ds & cs);
    adv = 1'b0;

    if (rstn) begin
      if (!m_busy) begin
        if (rdy) begin
          m_busy = 1; m_have = 0; m_killed = fl; m_pc = pcv;
          resp_at = cyc + lat; resp_word = next_word;
        end
      end else if (m_killed) begin
        if (rsp) m_busy = 0;
      end else if (!m_have) begin
        if (rsp) begin
          m_data = rdata;
          if (fl) m_busy = 0;
          else if (st) m_have = 1;
          else adv = 1'b1;
        end else if (fl) begin
          m_killed = 1;
        end
      end else begin
        if (fl) m_busy = 0;
        else if (!st) adv = 1'b1;
      end
      if (adv) m_busy = 0;

      if (fl) begin
        m_iv = 1'b0; m_ii = NOPV;
      end else if (!st) begin
        if (adv) begin
          m_iv = 1'b1; m_ii = m_data; m_in = m_pc + 32'd4;
        end else begin
          m_iv = 1'b0; m_ii = NOPV;
        end
      end
    end
    e.adv    = adv;
    last_adv = adv;
    sbq.push_back(e);
  endtask

  // Monitor: compares each cycle's outputs against the queued prediction.
  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        me = sbq.pop_front();
        chk1("req_valid", imem.imem_req_valid, me.rv);
        if (me.rv) chk("req_addr", imem.imem_req_addr, me.addr);
        chk("npc_inc4", NPC_increment_4, me.npc4);
        chk1("pc_advance_n", pc_advance_n, me.adv);
        chk1("if_id_valid", IF_ID_valid, me.iv);
        chk("if_id_instr", IF_ID_instr, me.ii);
        chk("if_id_npc", IF_ID_NPC, me.in);
      end
    end
  end

  initial begin : driver
    logic        rdy, ds, cs, br, jp, prev_fl;
    logic [31:0] pcv;
    imem.imem_req_ready  = 1'b0;
    imem.imem_resp_valid = 1'b0;
    imem.imem_resp_data  = 32'h0;

    // Power-on reset
    cycle(0, 1, 1, 1, 0, 0, 32'h0);
    cycle(0, 1, 1, 1, 0, 0, 32'h0);
    #3;
    chk1("rst_req_valid", imem.imem_req_valid, 1'b0);
    chk1("rst_adv", pc_advance_n, 1'b0);
    chk("rst_instr", IF_ID_instr, NOPV);
    chk("rst_npc", IF_ID_NPC, 32'h0);

    // Basic fetch, response two cycles after acceptance
    lat = 2; next_word = 32'h2402_0005;
    cycle(1, 1, 1, 1, 0, 0, 32'h0);
    cycle(1, 1, 1, 1, 0, 0, 32'h0);
    cycle(1, 1, 1, 1, 0, 0, 32'h0);
    #3 chk1("t1_adv", pc_advance_n, 1'b1);
    cycle(1, 0, 1, 1, 0, 0, 32'h4);
    #3;
    chk("t1_instr", IF_ID_instr, 32'h2402_0005);
    chk("t1_npc", IF_ID_NPC, 32'h4);
    chk1("t1_valid", IF_ID_valid, 1'b1);
    chk1("t1_adv_once", pc_advance_n, 1'b0);

    // Response lands during a three-cycle data stall
    lat = 1; next_word = 32'hA5A5_0001;
    cycle(1, 1, 1, 1, 0, 0, 32'h4);
    cycle(1, 0, 0, 1, 0, 0, 32'h4);
    cycle(1, 0, 0, 1, 0, 0, 32'h4);
    cycle(1, 0, 0, 1, 0, 0, 32'h4);
    #3 chk1("t2_adv_stalled", pc_advance_n, 1'b0);
    cycle(1, 0, 1, 1, 0, 0, 32'h4);
    #3 chk1("t2_adv_release", pc_advance_n, 1'b1);
    cycle(1, 0, 1, 1, 0, 0, 32'h8);
    #3;
    chk("t2_instr", IF_ID_instr, 32'hA5A5_0001);
    chk("t2_npc", IF_ID_NPC, 32'h8);

    // Branch while waiting; the late response must be dropped
    lat = 2; next_word = 32'hDEAD_BEEF;
    cycle(1, 1, 1, 1, 0, 0, 32'h8);
    cycle(1, 1, 1, 1, 1, 0, 32'h8);
    cycle(1, 0, 1, 1, 0, 0, 32'h100);
    #3 chk1("t3_valid_flushed", IF_ID_valid, 1'b0);
    lat = 1; next_word = 32'h1111_0000;
    cycle(1, 1, 1, 1, 0, 0, 32'h100);
    #3;
    chk1("t3_req_valid", imem.imem_req_valid, 1'b1);
    chk("t3_req_addr", imem.imem_req_addr, 32'h100);
    cycle(1, 0, 1, 1, 0, 0, 32'h100);
    cycle(1, 0, 1, 1, 0, 0, 32'h104);
    #3 chk("t3_instr", IF_ID_instr, 32'h1111_0000);

    // Fetch at the top of the address space
    lat = 1; next_word = 32'h0BAD_F00D;
    cycle(1, 1, 1, 1, 0, 0, 32'hFFFF_FFFC);
    #3 chk("t4_npc_inc4", NPC_increment_4, 32'h0);
    cycle(1, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    cycle(1, 0, 1, 1, 0, 0, 32'h0);
    #3;
    chk("t4_if_npc", IF_ID_NPC, 32'h0);
    chk1("t4_valid", IF_ID_valid, 1'b1);

    // Reset while waiting; the stale response arrives after release
    lat = 3; next_word = 32'hBAD0_BAD0;
    cycle(1, 1, 1, 1, 0, 0, 32'h200);
    cycle(0, 1, 1, 1, 0, 0, 32'h200);
    #3;
    chk1("t5_req_valid", imem.imem_req_valid, 1'b0);
    chk1("t5_valid", IF_ID_valid, 1'b0);
    chk("t5_npc", IF_ID_NPC, 32'h0);
    cycle(1, 0, 1, 1, 0, 0, 32'h200);
    cycle(1, 0, 1, 1, 0, 0, 32'h200);
    lat = 1; next_word = 32'h0C0F_FEE0;
    cycle(1, 1, 1, 1, 0, 0, 32'h300);
    #3 chk("t5_req_addr", imem.imem_req_addr, 32'h300);
    cycle(1, 0, 1, 1, 0, 0, 32'h300);
    cycle(1, 0, 1, 1, 0, 0, 32'h304);
    #3 chk("t5_instr", IF_ID_instr, 32'h0C0F_FEE0);

    // Memory not ready for four cycles
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 1, 1, 0, 0, 32'h400);
      #3;
      chk1("t6_req_valid", imem.imem_req_valid, 1'b1);
      chk("t6_req_addr", imem.imem_req_addr, 32'h400);
    end
    lat = 2; next_word = 32'h7777_0400;
    cycle(1, 1, 1, 1, 0, 0, 32'h400);
    cycle(1, 0, 1, 1, 0, 0, 32'h400);
    cycle(1, 0, 1, 1, 0, 0, 32'h400);

    // Random traffic
    prev_fl = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rdy = ($urandom % 10) < 7;
      ds  = ($urandom % 4) != 0;
      cs  = ($urandom % 10) != 0;
      br  = ($urandom % 12) == 0;
      jp  = ($urandom % 25) == 0;
      lat = 1 + int'($urandom % 4);
      next_word = $urandom;
      if (prev_fl) begin
        pcv = ($urandom % 6 == 0) ? 32'hFFFF_FFF0 + {28'h0, 2'($urandom % 4), 2'b00}
                                  : {$urandom % 32'h4000_0000, 2'b00};
      end else if (last_adv) begin
        pcv = PC + 32'd4;
      end else begin
        pcv = PC;
      end
      cycle(1, rdy, ds, cs, br, jp, pcv);
      prev_fl = br | jp;
    end

    @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
